// File: rtl/imem_loader.sv
// imem_loader: receives a byte-stream program image (count, big-endian words, checksum),
// writes it into instruction memory word by word and holds the CPU until the load succeeds.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]        state, state_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       part_q, part_d;
    logic [7:0]        words_d;
    logic              take;
    logic              in_ready_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic              cpu_hold_d;
    logic              done_d;
    logic              err_d;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d     = state;
        count_d     = count_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        part_d      = part_q;
        words_d     = words_loaded;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        take        = in_valid && in_ready;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_COUNT;
                    acc_d   = 8'd0;
                    idx_d   = 2'd0;
                    words_d = 8'd0;
                end
            end
            S_COUNT: begin
                if (take) begin
                    if ((in_byte == 8'd0) || (32'(in_byte) > MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        count_d = in_byte;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    acc_d = acc_q + in_byte;
                    if (idx_q == 2'd3) begin
                        // Word complete: present it to memory during the WRITE cycle
                        idx_d       = 2'd0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(BASE_ADDR + (32'(words_loaded) << 2));
                        mem_wdata_d = {part_q, in_byte};
                        state_d     = S_WRITE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        part_d = {part_q[15:0], in_byte};
                    end
                end
            end
            S_WRITE: begin
                words_d = words_loaded + 8'd1;
                state_d = ((words_loaded + 8'd1) == count_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (take) begin
                    state_d = (in_byte == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CSUM);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state        <= S_IDLE;
            count_q      <= 8'd0;
            acc_q        <= 8'd0;
            idx_q        <= 2'd0;
            part_q       <= 24'd0;
            words_loaded <= 8'd0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            part_q       <= part_d;
            words_loaded <= words_d;
            in_ready     <= in_ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            cpu_hold     <= cpu_hold_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of directed images, hand sequences, random images vs. a model.
module tb_imem_loader;

    logic        Clk      = 1'b0;
    logic        Clr      = 1'b0;
    logic        start    = 1'b0;
    logic [7:0]  in_byte  = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(64)) dut (
        .Clk(Clk), .Clr(Clr), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [0:11][7:0] img;
        int               len;
        int               gap;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_words;
        int               nw;
        logic [7:0]       a0;
        logic [31:0]      d0;
        logic [7:0]       a1;
        logic [31:0]      d1;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    wr_t        seen_q[$];
    wr_t        exp_q[$];
    logic [7:0] cur_img[$];
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_words;
    vec_t       tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    // Record every memory write; in_ready must be low whenever a write is presented
    always @(negedge Clk) begin
        if (Clr && mem_we) begin
            seen_q.push_back({mem_addr, mem_wdata});
            check("in_ready_during_write", 32'(in_ready), 32'd0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: derive writes and final status from the image bytes
    task automatic model_expect();
        int n;
        int sum;
        exp_q.delete();
        n = int'(cur_img[0]);
        if (n == 0 || n > 64) begin
            exp_done  = 1'b0;
            exp_err   = 1'b1;
            exp_words = 8'd0;
        end else begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({8'((4 * i) % 256),
                                 cur_img[1+4*i], cur_img[2+4*i], cur_img[3+4*i], cur_img[4+4*i]});
                for (int k = 1; k <= 4; k++) sum += int'(cur_img[4*i+k]);
            end
            exp_done  = (8'(sum % 256) == cur_img[1+4*n]);
            exp_err   = !exp_done;
            exp_words = 8'(n);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_done_err", {30'd0, done, err}, 32'd0);
        check("start_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
        end else begin
            @(negedge Clk);
        end
        in_valid = 1'b0;
        in_byte  = $urandom_range(0, 255);
        repeat (gap) @(negedge Clk);
    endtask

    task automatic send_range(input int from, input int to, input int gap, input bit rnd);
        for (int i = from; i < to; i++)
            send_byte(cur_img[i], rnd ? $urandom_range(0, 2) : gap);
    endtask

    task automatic finish_check(input string nm);
        int n = 0;
        while (!(done || err) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        check({nm, "_done"}, 32'(done), 32'(exp_done));
        check({nm, "_err"}, 32'(err), 32'(exp_err));
        check({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({nm, "_in_ready"}, 32'(in_ready), 32'd0);
        check({nm, "_words"}, 32'(words_loaded), 32'(exp_words));
        check({nm, "_nwrites"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check({nm, "_waddr"}, 32'(seen_q[i].addr), 32'(exp_q[i].addr));
            check({nm, "_wdata"}, seen_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic load_t1();
        cur_img = {8'h02, 8'hE3, 8'hA0, 8'h10, 8'h05, 8'hE2, 8'h81, 8'h10, 8'h01, 8'h0C};
        exp_q.delete();
        exp_q.push_back({8'h00, 32'hE3A01005});
        exp_q.push_back({8'h04, 32'hE2811001});
        exp_done  = 1'b1;
        exp_err   = 1'b0;
        exp_words = 8'd2;
    endtask

    initial begin
        logic [7:0] n;
        int         sum;

        tbl[0] = '{96'h02E3A01005E28110010C0000, 10, 0, 1'b1, 1'b0, 8'd2, 2, 8'h00, 32'hE3A01005, 8'h04, 32'hE2811001};
        tbl[1] = '{96'h02E3A01005E28110010D0000, 10, 0, 1'b0, 1'b1, 8'd2, 2, 8'h00, 32'hE3A01005, 8'h04, 32'hE2811001};
        tbl[2] = '{96'h000000000000000000000000, 1, 0, 1'b0, 1'b1, 8'd0, 0, 8'h00, 32'h0, 8'h00, 32'h0};
        tbl[3] = '{96'h410000000000000000000000, 1, 0, 1'b0, 1'b1, 8'd0, 0, 8'h00, 32'h0, 8'h00, 32'h0};
        tbl[4] = '{96'h02E3A01005E28110010C0000, 10, 3, 1'b1, 1'b0, 8'd2, 2, 8'h00, 32'hE3A01005, 8'h04, 32'hE2811001};
        tbl[5] = '{96'h010000000000000000000000, 6, 0, 1'b1, 1'b0, 8'd1, 1, 8'h00, 32'h00000000, 8'h00, 32'h0};

        // Reset values
        repeat (2) @(negedge Clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        Clr = 1'b1;
        repeat (2) @(negedge Clk);

        // Directed images from the table
        for (int t = 0; t < 6; t++) begin
            cur_img.delete();
            for (int i = 0; i < tbl[t].len; i++) cur_img.push_back(tbl[t].img[i]);
            exp_q.delete();
            if (tbl[t].nw > 0) exp_q.push_back({tbl[t].a0, tbl[t].d0});
            if (tbl[t].nw > 1) exp_q.push_back({tbl[t].a1, tbl[t].d1});
            exp_done  = tbl[t].exp_done;
            exp_err   = tbl[t].exp_err;
            exp_words = tbl[t].exp_words;
            seen_q.delete();
            pulse_start();
            send_range(0, cur_img.size(), tbl[t].gap, 1'b0);
            finish_check($sformatf("tbl%0d", t));
        end

        // Reset in the middle of a load, then a clean reload
        load_t1();
        seen_q.delete();
        pulse_start();
        send_range(0, 6, 0, 1'b0);
        #2 Clr = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done_err", {30'd0, done, err}, 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        seen_q.delete();
        pulse_start();
        send_range(0, cur_img.size(), 0, 1'b0);
        finish_check("after_reset");

        // start during DATA is ignored
        load_t1();
        seen_q.delete();
        pulse_start();
        send_range(0, 3, 0, 1'b0);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("ign_start_in_ready", 32'(in_ready), 32'd1);
        send_range(3, cur_img.size(), 1, 1'b0);
        finish_check("ign_start");

        // start with a valid byte in DONE: byte is not consumed on that edge
        cur_img = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_expect();
        seen_q.delete();
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h01;
        @(negedge Clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_valid_cpu_hold", 32'(cpu_hold), 32'd1);
        check("start_valid_words", 32'(words_loaded), 32'd0);
        send_range(0, cur_img.size(), 0, 1'b0);
        finish_check("start_valid");

        // Random images against the reference model
        for (int r = 0; r < 25; r++) begin
            int sel = $urandom_range(0, 9);
            if (sel == 0)      n = 8'd0;
            else if (sel == 1) n = 8'($urandom_range(65, 255));
            else if (sel == 2) n = 8'd64;
            else               n = 8'($urandom_range(1, 6));
            cur_img.delete();
            cur_img.push_back(n);
            if (n != 8'd0 && n <= 8'd64) begin
                sum = 0;
                for (int i = 0; i < 4 * int'(n); i++) begin
                    cur_img.push_back(8'($urandom_range(0, 255)));
                    sum += int'(cur_img[i+1]);
                end
                cur_img.push_back(8'(sum) ^ (($urandom_range(0, 3) == 0) ? 8'h5A : 8'h00));
            end
            model_expect();
            seen_q.delete();
            pulse_start();
            send_range(0, cur_img.size(), 0, 1'b1);
            finish_check($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
